// File: rtl/ota_cmp_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ota_cmp_scan_sequencer
// Description : Time-multiplexes one OTA comparator across NCH channel pairs.
//               Each channel in the captured mask is selected and given
//               SETTLE_CYCLES to settle. SAMPLES votes of cmp_out are then
//               taken, and one majority-decided result bit is committed.
//               Runs as a single-shot scan or as a continuous scan.
// Options     : CMP_HYST_EN - when defined, a result bit only changes on a
//               unanimous vote (all ones -> 1, all zeros -> 0).
// Revision    : 1.0 - initial release
// ============================================================================
module ota_cmp_scan_sequencer #(
  parameter int NCH           = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int SAMPLES       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [NCH-1:0]           ch_mask,
  input  logic                     cmp_out,
  output logic [$clog2(NCH)-1:0]   cmp_sel,
  output logic                     cmp_en,
  output logic [NCH-1:0]           result,
  output logic                     ch_valid,
  output logic [$clog2(NCH)-1:0]   ch_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int CW      = $clog2(NCH);
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [NCH-1:0]  result_q, result_d;
  logic [3:0]      ones_q, ones_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [CW-1:0]   w_low_ch;
  logic [CW-1:0]   w_next_ch;
  logic            w_next_found;
  logic            w_commit_bit;

  // Lowest set bit of the live mask: first channel of a fresh scan or a wrap.
  always_comb begin
    w_low_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) w_low_ch = CW'(i);
    end
  end

  // Next set bit of the captured mask strictly above the current channel.
  always_comb begin
    w_next_ch    = '0;
    w_next_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (CW'(i) > ch_q)) begin
        w_next_ch    = CW'(i);
        w_next_found = 1'b1;
      end
    end
  end

`ifdef CMP_HYST_EN
  // Unanimous vote required to flip a bit; mixed votes keep the old decision.
  always_comb begin
    if (ones_q == 4'(SAMPLES)) begin
      w_commit_bit = 1'b1;
    end else if (ones_q == 4'd0) begin
      w_commit_bit = 1'b0;
    end else begin
      w_commit_bit = result_q[ch_q];
    end
  end
`else
  // Strict majority: 2*ones > SAMPLES, so a tie resolves to 0.
  always_comb begin
    w_commit_bit = ({1'b0, ones_q, 1'b0} > 6'(SAMPLES));
  end
`endif

  // Scan sequencing: channel selection, settle/sample timing, vote count, commit.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    result_d = result_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = ch_mask;
          if (|ch_mask) begin
            state_d = S_SETTLE;
            ch_d    = w_low_ch;
            cnt_d   = '0;
            ones_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNTW'(SETTLE_CYCLES - 1)) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (cmp_out) ones_d = ones_q + 4'd1;
        if (cnt_q == CNTW'(SAMPLES - 1)) begin
          state_d = S_COMMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        result_d[ch_q] = w_commit_bit;
        ones_d         = '0;
        cnt_d          = '0;
        if (w_next_found) begin
          state_d = S_SETTLE;
          ch_d    = w_next_ch;
        end else if (continuous) begin
          // Wrap: a new mask is taken so the channel set can change between passes.
          mask_d = ch_mask;
          if (|ch_mask) begin
            state_d = S_SETTLE;
            ch_d    = w_low_ch;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any transition; a commit in progress is dropped.
    if (abort) begin
      state_d  = S_IDLE;
      ch_d     = ch_q;
      mask_d   = mask_q;
      result_d = result_q;
      ones_d   = '0;
      cnt_d    = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      mask_q   <= '0;
      result_q <= '0;
      ones_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      ones_q   <= ones_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmp_sel = ch_q;
  assign ch_idx  = ch_q;
  assign result  = result_q;
  assign cmp_en  = (state_q == S_SETTLE) || (state_q == S_SAMPLE) || (state_q == S_COMMIT);
  assign busy    = (state_q != S_IDLE);
  // An abort in the same cycle cancels the write/finish, so the pulses are masked too.
  assign ch_valid = (state_q == S_COMMIT) && !abort;
  assign done     = (state_q == S_DONE) && !abort;

endmodule
`default_nettype wire

// File: tb/tb_ota_cmp_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ota_cmp_scan_sequencer
// Description : Self-checking bench for ota_cmp_scan_sequencer. It runs
//               directed scans, then randomized scans, and compares the DUT
//               against a channel-visit timeline model on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ota_cmp_scan_sequencer;

  localparam int NCH   = 4;
  localparam int SET   = 3;
  localparam int SMP   = 4;
  localparam int VISIT = SET + SMP + 1;
  localparam int CW    = $clog2(NCH);

  logic           clk = 1'b0;
  logic           rst_n, start, abort, continuous, cmp_out;
  logic [NCH-1:0] ch_mask;
  logic [CW-1:0]  cmp_sel, ch_idx;
  logic           cmp_en, ch_valid, busy, done;
  logic [NCH-1:0] result;

  always #5 clk = ~clk;

  ota_cmp_scan_sequencer #(.NCH(NCH), .SETTLE_CYCLES(SET), .SAMPLES(SMP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
    .ch_mask(ch_mask), .cmp_out(cmp_out), .cmp_sel(cmp_sel), .cmp_en(cmp_en),
    .result(result), .ch_valid(ch_valid), .ch_idx(ch_idx), .busy(busy), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: channel-visit timeline ----------------
  // mode 0 idle, 1 visiting a channel (pos counts 0..VISIT-1), 2 finishing
  int             m_mode = 0, m_pos = 0, m_ch = 0, m_votes = 0;
  logic [NCH-1:0] m_mask = '0, m_result = '0;
  bit             m_valid = 1'b0;

  function automatic int first_set_above(input logic [NCH-1:0] m, input int above);
    for (int i = above + 1; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic decide(input logic prev, input int votes);
`ifdef CMP_HYST_EN
    if (votes == SMP) return 1'b1;
    if (votes == 0) return 1'b0;
    return prev;
`else
    return (2 * votes > SMP);
`endif
  endfunction

  task automatic model_step();
    int nxt;
    if (!rst_n) begin
      m_valid = 1'b1; m_mode = 0; m_pos = 0; m_ch = 0; m_votes = 0;
      m_mask = '0; m_result = '0;
      return;
    end
    if (!m_valid) return;
    if (abort) begin
      m_mode = 0; m_votes = 0;
      return;
    end
    case (m_mode)
      0: if (start) begin
        m_mask = ch_mask;
        if (ch_mask != '0) begin
          m_mode = 1; m_ch = first_set_above(ch_mask, -1); m_pos = 0; m_votes = 0;
        end else m_mode = 2;
      end
      1: begin
        if (m_pos >= SET && m_pos < SET + SMP && cmp_out) m_votes++;
        if (m_pos == VISIT - 1) begin
          m_result[m_ch] = decide(m_result[m_ch], m_votes);
          m_votes = 0; m_pos = 0;
          nxt = first_set_above(m_mask, m_ch);
          if (nxt >= 0) m_ch = nxt;
          else if (continuous) begin
            m_mask = ch_mask;
            if (ch_mask != '0) m_ch = first_set_above(ch_mask, -1);
            else m_mode = 2;
          end else m_mode = 2;
        end else m_pos++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic e_valid;
    if (!m_valid) return;
    e_valid = (m_mode == 1) && (m_pos == VISIT - 1) && !abort;
    check_eq("busy", busy, m_mode != 0);
    check_eq("cmp_en", cmp_en, m_mode == 1);
    check_eq("ch_valid", ch_valid, e_valid);
    check_eq("done", done, (m_mode == 2) && !abort);
    check_eq("result", result, m_result);
    if (m_mode == 1) check_eq("cmp_sel", cmp_sel, m_ch);
    if (e_valid) check_eq("ch_idx", ch_idx, m_ch);
  endtask

  logic          cap_valid, cap_done, cap_en, cap_busy;
  logic [CW-1:0] cap_idx;

  // One clock: outputs checked against the model, then the model advances.
  task automatic tick();
    #1;
    cap_valid = ch_valid; cap_idx = ch_idx; cap_done = done;
    cap_en = cmp_en; cap_busy = busy;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- directed scan runner ----------------
  int       v_cnt, d_cnt, d_cyc, en_cnt;
  int       v_cyc[16], v_idx[16];
  logic     b_hist[64];
  logic [3:0] pat;
  int       ab_at, re_at;
  logic [NCH-1:0] re_mask;

  task automatic run_scan(input int ncyc, input bit do_start, input logic [NCH-1:0] m);
    int ph;
    v_cnt = 0; d_cnt = 0; d_cyc = -1; en_cnt = 0;
    rst_n = 1'b1; abort = 1'b0; cmp_out = 1'b0;
    if (do_start) begin
      start = 1'b1; ch_mask = m;
      tick();
    end
    for (int c = 1; c <= ncyc; c++) begin
      ph = (c - 1) % VISIT - SET;
      cmp_out = (ph >= 0 && ph < SMP) ? pat[3 - ph] : 1'b0;
      abort = (c == ab_at);
      start = (c == re_at);
      if (c == re_at) ch_mask = re_mask;
      tick();
      if (c < 64) b_hist[c] = cap_busy;
      if (cap_en) en_cnt++;
      if (cap_valid) begin
        if (v_cnt < 16) begin v_cyc[v_cnt] = c; v_idx[v_cnt] = int'(cap_idx); end
        v_cnt++;
      end
      if (cap_done) begin
        if (d_cyc < 0) d_cyc = c;
        d_cnt++;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_single(input logic [NCH-1:0] m, input logic [3:0] p);
    pat = p; ab_at = -1; re_at = -1;
    run_scan(12, 1'b1, m);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    ch_mask = '0; cmp_out = 1'b0;
    ab_at = -1; re_at = -1; re_mask = '0; pat = 4'b1111;
    tick(); tick();
    // reset state, still under reset
    tick();
    check_eq("rst_busy", cap_busy, 1'b0);
    check_eq("rst_result", result, '0);

    // mask 0101, cmp_out high: commits at 8 and 16, done at 17
    run_scan(20, 1'b1, 4'b0101);
    check_eq("s1_vcnt", v_cnt, 2);
    check_eq("s1_v0cyc", v_cyc[0], 8);
    check_eq("s1_v0idx", v_idx[0], 0);
    check_eq("s1_v1cyc", v_cyc[1], 16);
    check_eq("s1_v1idx", v_idx[1], 2);
    check_eq("s1_done", d_cyc, 17);
    check_eq("s1_result", result, 4'b0101);

    // vote patterns on channel 0
    run_single(4'b0001, 4'b1100);
`ifdef CMP_HYST_EN
    check_eq("tie_hyst", result[0], 1'b1);
`else
    check_eq("tie", result[0], 1'b0);
`endif
    run_single(4'b0001, 4'b1110);
    check_eq("maj3", result[0], 1'b1);
    run_single(4'b0001, 4'b1000);
`ifdef CMP_HYST_EN
    check_eq("one_vote_hyst", result[0], 1'b1);
`else
    check_eq("one_vote", result[0], 1'b0);
`endif
    run_single(4'b0001, 4'b0000);
    check_eq("zero_votes", result[0], 1'b0);
    check_eq("vote_done", d_cyc, 9);

    // continuous on channel 3, then stop after the current pass
    continuous = 1'b1; pat = 4'b1111;
    run_scan(40, 1'b1, 4'b1000);
    check_eq("cont_vcnt", v_cnt, 5);
    check_eq("cont_idx", v_idx[4], 3);
    check_eq("cont_nodone", d_cnt, 0);
    continuous = 1'b0;
    run_scan(10, 1'b0, 4'b1000);
    check_eq("stop_vcnt", v_cnt, 1);
    check_eq("stop_done", d_cyc, 9);
    check_eq("stop_idle", b_hist[10], 1'b0);
    check_eq("stop_result", result, 4'b1100);

    // abort in cycle 5
    ab_at = 5;
    run_scan(10, 1'b1, 4'b1111);
    ab_at = -1;
    check_eq("abort_busy5", b_hist[5], 1'b1);
    check_eq("abort_idle6", b_hist[6], 1'b0);
    check_eq("abort_nov", v_cnt, 0);
    check_eq("abort_nodone", d_cnt, 0);
    check_eq("abort_result", result, 4'b1100);

    // empty mask: done next cycle, comparator never enabled
    run_scan(4, 1'b1, 4'b0000);
    check_eq("empty_done", d_cyc, 1);
    check_eq("empty_en", en_cnt, 0);
    check_eq("empty_result", result, 4'b1100);

    // start while busy is ignored
    re_at = 3; re_mask = 4'b0011; pat = 4'b0111;
    run_scan(20, 1'b1, 4'b0101);
    re_at = -1;
    check_eq("busy_vcnt", v_cnt, 2);
    check_eq("busy_v1idx", v_idx[1], 2);
    check_eq("busy_done", d_cyc, 17);

    // randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      if ($urandom_range(0, 7) == 0) ch_mask = NCH'($urandom);
      cmp_out = ($urandom_range(0, 3) != 0) ^ (c[9]);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
